// File: rtl/clk_rst_sequencer.sv
// DCM supervisor and staggered reset sequencer: pulses the DCM reset, waits for lock,
// retries on timeout or clkfx stop, then releases downstream resets one channel at a time.
module clk_rst_sequencer #(
   parameter int CHANNELS       = 3,
   parameter int SYNC_STAGES    = 2,
   parameter int DCM_RST_CYCLES = 4,
   parameter int LOCK_TIMEOUT   = 65536,
   parameter int STAGGER_CYCLES = 256,
   parameter int MAX_RETRIES    = 8,
   parameter int CNT_WIDTH      = 17
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                lock_in,
   input  logic                clkfx_stopped,
   output logic                dcm_rst,
   output logic [CHANNELS-1:0] rst_out,
   output logic                ready,
   output logic [7:0]          retry_count,
   output logic                fault
);

   localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   localparam logic [2:0] ST_DCM_RST   = 3'd0;
   localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [2:0] ST_RELEASE   = 3'd2;
   localparam logic [2:0] ST_RUN       = 3'd3;
   localparam logic [2:0] ST_FAULT     = 3'd4;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] RST_LAST = CNT_WIDTH'(DCM_RST_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] LTO_LAST = CNT_WIDTH'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_WIDTH-1:0] STG_LAST = CNT_WIDTH'(STAGGER_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_ONE  = IDX_W'(1);
   localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(CHANNELS - 1);
   localparam logic [7:0]           RETRY_LIMIT = 8'(MAX_RETRIES);

   logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
   logic [SYNC_STAGES-1:0] stop_sync_q, stop_sync_d;
   logic                   lock_s, stop_s;
   logic [2:0]             state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [7:0]             retry_q, retry_d, retry_inc;
   logic                   dcm_rst_q, dcm_rst_d;
   logic                   ready_q, ready_d;
   logic                   fault_q, fault_d;
   logic [CHANNELS-1:0]    rst_out_q, rst_out_d;
   logic [CHANNELS-1:0]    idx_mask;

   assign lock_s = lock_sync_q[SYNC_STAGES-1];
   assign stop_s = stop_sync_q[SYNC_STAGES-1];

   always_comb begin
      idx_mask = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         idx_mask[i] = (IDX_W'(i) == idx_q);
      end
   end

   always_comb begin
      lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], lock_in};
      stop_sync_d = {stop_sync_q[SYNC_STAGES-2:0], clkfx_stopped};
      retry_inc   = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;

      state_d   = state_q;
      cnt_d     = cnt_q + CNT_ONE;
      idx_d     = idx_q;
      retry_d   = retry_q;
      rst_out_d = rst_out_q;

      case (state_q)
         ST_DCM_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = ST_WAIT_LOCK;
               cnt_d   = '0;
            end
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout or clkfx stop.
            if (lock_s) begin
               state_d = ST_RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
               retry_d = '0;
            end else if (stop_s || (cnt_q == LTO_LAST)) begin
               retry_d = retry_inc;
               cnt_d   = '0;
               state_d = (retry_inc >= RETRY_LIMIT) ? ST_FAULT : ST_DCM_RST;
            end
         end
         ST_RELEASE: begin
            if (!lock_s) begin
               state_d = ST_DCM_RST;
               cnt_d   = '0;
            end else if (cnt_q == STG_LAST) begin
               cnt_d     = '0;
               rst_out_d = rst_out_q & ~idx_mask;
               idx_d     = idx_q + IDX_ONE;
               if (idx_q == IDX_LAST) begin
                  state_d = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            cnt_d = cnt_q;
            if (!lock_s) begin
               state_d = ST_DCM_RST;
               cnt_d   = '0;
            end
         end
         ST_FAULT: begin
            cnt_d = cnt_q;
         end
         default: begin
            state_d = ST_DCM_RST;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered from the next state so they line up with state_q.
      if (state_d == ST_RUN) begin
         rst_out_d = '0;
      end else if (state_d != ST_RELEASE) begin
         rst_out_d = '1;
      end
      dcm_rst_d = (state_d == ST_DCM_RST) || (state_d == ST_FAULT);
      ready_d   = (state_d == ST_RUN);
      fault_d   = (state_d == ST_FAULT);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         lock_sync_q <= '0;
         stop_sync_q <= '0;
         state_q     <= ST_DCM_RST;
         cnt_q       <= '0;
         idx_q       <= '0;
         retry_q     <= '0;
         dcm_rst_q   <= 1'b1;
         rst_out_q   <= '1;
         ready_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         lock_sync_q <= lock_sync_d;
         stop_sync_q <= stop_sync_d;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         retry_q     <= retry_d;
         dcm_rst_q   <= dcm_rst_d;
         rst_out_q   <= rst_out_d;
         ready_q     <= ready_d;
         fault_q     <= fault_d;
      end
   end

   assign dcm_rst     = dcm_rst_q;
   assign rst_out     = rst_out_q;
   assign ready       = ready_q;
   assign retry_count = retry_q;
   assign fault       = fault_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Bench for clk_rst_sequencer: directed bring-up scenarios plus random lock activity,
// every cycle compared against a phase/elapsed-time reference model.
module tb_clk_rst_sequencer;

   localparam int CH  = 3;
   localparam int SYN = 2;
   localparam int DRC = 4;
   localparam int LTO = 64;
   localparam int STG = 8;
   localparam int MR  = 3;
   localparam int CW  = 17;

   localparam int PH_RST   = 0;
   localparam int PH_WAIT  = 1;
   localparam int PH_REL   = 2;
   localparam int PH_RUN   = 3;
   localparam int PH_FAULT = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          lock_in = 1'b0;
   logic          clkfx_stopped = 1'b0;
   logic          dcm_rst;
   logic [CH-1:0] rst_out;
   logic          ready;
   logic [7:0]    retry_count;
   logic          fault;

   int n_chk  = 0;
   int n_pass = 0;

   int m_ph;
   int m_t;
   int m_retry;
   bit lq[$];
   bit sq[$];

   always #5 clk = ~clk;

   clk_rst_sequencer #(
      .CHANNELS(CH), .SYNC_STAGES(SYN), .DCM_RST_CYCLES(DRC), .LOCK_TIMEOUT(LTO),
      .STAGGER_CYCLES(STG), .MAX_RETRIES(MR), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .reset_n(reset_n), .lock_in(lock_in), .clkfx_stopped(clkfx_stopped),
      .dcm_rst(dcm_rst), .rst_out(rst_out), .ready(ready), .retry_count(retry_count),
      .fault(fault)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic model_reset();
      m_ph = PH_RST;
      m_t = 0;
      m_retry = 0;
      lq.delete();
      sq.delete();
      for (int i = 0; i < SYN; i++) begin
         lq.push_back(1'b0);
         sq.push_back(1'b0);
      end
   endtask

   // One clock edge of the reference: lock/stop seen by the sequencer lag the pins by SYN edges.
   task automatic model_edge();
      bit ls, ss;
      ls = lq.pop_front();
      ss = sq.pop_front();
      lq.push_back(lock_in);
      sq.push_back(clkfx_stopped);
      case (m_ph)
         PH_RST: begin
            m_t++;
            if (m_t == DRC) begin m_ph = PH_WAIT; m_t = 0; end
         end
         PH_WAIT: begin
            if (ls) begin
               m_ph = PH_REL; m_t = 0; m_retry = 0;
            end else if (ss || (m_t + 1 == LTO)) begin
               m_retry = (m_retry < 255) ? m_retry + 1 : 255;
               m_ph = (m_retry >= MR) ? PH_FAULT : PH_RST;
               m_t = 0;
            end else begin
               m_t++;
            end
         end
         PH_REL: begin
            if (!ls) begin
               m_ph = PH_RST; m_t = 0;
            end else begin
               m_t++;
               if (m_t == CH * STG) m_ph = PH_RUN;
            end
         end
         PH_RUN: begin
            if (!ls) begin m_ph = PH_RST; m_t = 0; end
         end
         default: ;
      endcase
   endtask

   function automatic logic [CH-1:0] exp_rst_out();
      logic [CH-1:0] ones;
      ones = '1;
      if (m_ph == PH_RUN) return '0;
      if (m_ph == PH_REL) return ones << (m_t / STG);
      return ones;
   endfunction

   task automatic check_all();
      chk("dcm_rst", 32'(dcm_rst), 32'((m_ph == PH_RST) || (m_ph == PH_FAULT)));
      chk("rst_out", 32'(rst_out), 32'(exp_rst_out()));
      chk("ready", 32'(ready), 32'(m_ph == PH_RUN));
      chk("retry_count", 32'(retry_count), 32'(m_retry));
      chk("fault", 32'(fault), 32'(m_ph == PH_FAULT));
   endtask

   task automatic step(input bit l, input bit s);
      lock_in = l;
      clkfx_stopped = s;
      @(posedge clk);
      if (!reset_n) model_reset();
      else model_edge();
      @(negedge clk);
      check_all();
   endtask

   // Asserted mid-cycle so the outputs must react without any clock edge.
   task automatic apply_reset();
      #1;
      reset_n = 1'b0;
      #1;
      model_reset();
      chk("async_dcm_rst", 32'(dcm_rst), 32'd1);
      chk("async_rst_out", 32'(rst_out), 32'h7);
      chk("async_ready", 32'(ready), 32'd0);
      chk("async_fault", 32'(fault), 32'd0);
      chk("async_retry", 32'(retry_count), 32'd0);
      step(lock_in, clkfx_stopped);
      reset_n = 1'b1;
   endtask

   initial begin
      int max_retry;
      int hold;
      bit l;

      model_reset();
      @(negedge clk);
      chk("reset_dcm_rst", 32'(dcm_rst), 32'd1);
      chk("reset_rst_out", 32'(rst_out), 32'h7);
      chk("reset_ready", 32'(ready), 32'd0);
      check_all();
      reset_n = 1'b1;

      // Normal bring-up
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
      chk("bringup_ready", 32'(ready), 32'd1);
      chk("bringup_rst_out", 32'(rst_out), 32'd0);
      chk("bringup_retry", 32'(retry_count), 32'd0);

      // Two timeouts, then lock
      apply_reset();
      max_retry = 0;
      for (int i = 0; i < 250; i++) begin
         step(i >= 150, 1'b0);
         if (int'(retry_count) > max_retry) max_retry = int'(retry_count);
      end
      chk("timeout_max_retry", 32'(max_retry), 32'd2);
      chk("timeout_ready", 32'(ready), 32'd1);
      chk("timeout_retry_cleared", 32'(retry_count), 32'd0);

      // Fault after MR timeouts; lock afterwards is ignored
      apply_reset();
      for (int i = 0; i < 250; i++) step(1'b0, 1'b0);
      chk("fault_flag", 32'(fault), 32'd1);
      chk("fault_retry", 32'(retry_count), 32'd3);
      chk("fault_dcm_rst", 32'(dcm_rst), 32'd1);
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
      chk("fault_sticky", 32'(fault), 32'd1);
      apply_reset();
      chk("fault_cleared", 32'(fault), 32'd0);

      // clkfx_stopped forces an early retry
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0);
      step(1'b0, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 1'b0);
      chk("stop_retry", 32'(retry_count), 32'd1);
      chk("stop_no_fault", 32'(fault), 32'd0);

      // One-cycle lock loss in RUN
      apply_reset();
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0);
      chk("run_before_loss", 32'(ready), 32'd1);
      step(1'b0, 1'b0);
      for (int i = 0; i < 60; i++) step(1'b1, 1'b0);
      chk("relock_ready", 32'(ready), 32'd1);
      chk("relock_retry", 32'(retry_count), 32'd0);

      // Lock loss mid-release, then async reset mid-release
      apply_reset();
      for (int i = 0; i < 15; i++) step(1'b1, 1'b0);
      chk("mid_release", 32'(rst_out), 32'h6);
      step(1'b0, 1'b0);
      for (int i = 0; i < 18; i++) step(1'b1, 1'b0);
      apply_reset();

      // Random lock activity with occasional clkfx stops and resets
      hold = 0;
      l = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         if (hold == 0) begin
            l = ($urandom_range(0, 99) < 75);
            hold = int'($urandom_range(1, 150));
         end
         hold--;
         if ($urandom_range(0, 499) == 0) apply_reset();
         step(l, $urandom_range(0, 199) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/clk_rst_sequencer.md
Name: clk_rst_sequencer

Overview:
- Parametrised clock-manager supervisor and reset sequencer, one clock domain.
- Runs on the free-running board clock and drives the DCM reset pin.
- Watches the DCM lock and clkfx-stopped status and retries the DCM on lock timeout.
- Releases CHANNELS downstream reset outputs in staggered order; declares a sticky fault after repeated lock failures.

Parameters:
CHANNELS, 3, number of sequenced reset outputs (1..16)
SYNC_STAGES, 2, synchroniser depth for lock_in and clkfx_stopped (>=2)
DCM_RST_CYCLES, 4, width of each dcm_rst pulse in clk cycles (>=1)
LOCK_TIMEOUT, 65536, cycles to wait for synchronised lock before retry (>=1)
STAGGER_CYCLES, 256, cycles between successive channel releases (>=1)
MAX_RETRIES, 8, consecutive timeouts before fault (1..255)
CNT_WIDTH, 17, width of the shared cycle counter; must hold max(LOCK_TIMEOUT, STAGGER_CYCLES, DCM_RST_CYCLES)

Ports:
clk  input  1  free-running reference clock
reset_n  input  1  asynchronous active-low reset
lock_in  input  1  DCM LOCKED, asynchronous to clk
clkfx_stopped  input  1  DCM STATUS[2], asynchronous to clk
dcm_rst  output  1  DCM reset, active high
rst_out  output  CHANNELS  per-domain reset, active high; bit 0 released first
ready  output  1  high when all channels are released and lock is held
retry_count  output  8  consecutive lock-timeout count, saturating
fault  output  1  sticky; DCM gave up after MAX_RETRIES

Behaviour:
- Reset: clock is clk; reset is reset_n, asynchronous and active-low.
- Values while reset_n=0: dcm_rst=1, rst_out=all ones, ready=0, retry_count=0, fault=0, state=DCM_RST, counter=0, synchronisers=0.
- All outputs are registered.
- lock_s and stop_s are lock_in and clkfx_stopped passed through SYNC_STAGES flops. Input-to-FSM latency is SYNC_STAGES cycles.
- DCM_RST state:
  - dcm_rst=1 and rst_out=all ones.
  - Counter counts 0..DCM_RST_CYCLES-1.
  - On the terminal count, go to WAIT_LOCK with counter cleared.
  - dcm_rst is high for exactly DCM_RST_CYCLES cycles per pulse, counted from the first cycle after reset_n deasserts or from entry to the state.
- WAIT_LOCK state:
  - dcm_rst=0 and rst_out=all ones.
  - Counter increments every cycle.
  - lock_s=1: go to RELEASE, counter=0, retry_count=0.
  - stop_s=1 with lock_s=0: treat as a timeout immediately.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0: timeout.
  - On a timeout, retry_count increments, saturating at 255.
    - If the new value is >= MAX_RETRIES, go to FAULT.
    - Otherwise go to DCM_RST.
  - If lock_s=1 and a timeout occur in the same cycle, lock wins.
- RELEASE state:
  - Index k starts at 0.
  - After STAGGER_CYCLES cycles in the state, rst_out[0] clears.
  - Each further STAGGER_CYCLES cycles clears rst_out[k+1].
  - When rst_out[CHANNELS-1] clears, go to RUN. ready=1 from the same edge.
  - Released bits stay cleared; unreleased bits stay set.
- RUN state:
  - ready=1, rst_out=0, dcm_rst=0.
  - Stays in RUN while lock_s=1.
- Lock loss (lock_s=0 in RELEASE or RUN):
  - On the next edge, rst_out=all ones, ready=0, go to DCM_RST with counter=0.
  - retry_count is not incremented.
- FAULT state:
  - dcm_rst=1, rst_out=all ones, ready=0, fault=1.
  - Held until reset_n is asserted; lock_in is ignored.
- Counter never wraps: it is cleared on every state entry.
- ready is only ever 1 in RUN.

Test Plan:
Use CHANNELS=3, SYNC=2, DCM_RST_CYCLES=4, LOCK_TIMEOUT=64, STAGGER=8, MAX_RETRIES=3.
1. Normal bring-up: lock_in=1 from 10 cycles after reset_n rises -> dcm_rst high for cycles 1-4; rst_out 111->110->100->000 at 8-cycle spacing; ready=1 with final release; retry_count=0.
2. Timeout retry: lock_in=0 for 150 cycles then 1 -> two 4-cycle dcm_rst pulses spaced 64+4 cycles apart; retry_count reaches 2, then clears to 0 on lock; sequence then completes.
3. Fault: lock_in held 0 -> third timeout gives fault=1, dcm_rst=1 steady, retry_count=3; lock_in=1 later has no effect; reset_n pulse clears fault.
4. clkfx_stopped=1 in WAIT_LOCK with lock_in=0 -> retry begins SYNC_STAGES+1 cycles later, well before 64-cycle timeout; retry_count increments.
5. Lock loss in RUN: drop lock_in for 1 cycle -> rst_out=111, ready=0 within SYNC_STAGES+1 cycles; new dcm_rst pulse; retry_count unchanged; full re-sequence.
6. Lock loss mid-RELEASE after rst_out=110 -> rst_out returns to 111 on the next edge after lock_s falls; async reset_n mid-RELEASE -> all outputs return to reset values immediately, without waiting for a clk edge.
